// File: rtl/mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux8_rr_scheduler
//
// Round-robin scheduler for an 8:1 multiplexed data path. Arbitrates eight
// level-sensitive request lines and drives the 3-bit select of the external
// mux tree. Each grant lasts at most BURST_LEN cycles. The selected data bit
// is registered onto y.
//
// Optional feature: define MUX8_SCHED_GAP_EN to insert one guard cycle after
// every grant. During that cycle grant=0, busy=0 and done=1. Without the
// macro, grants follow each other back-to-back.
//
// Parameters
//   BURST_LEN  maximum consecutive granted cycles per grant (1..255)
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   req    in   [7:0] request per source, bit i = source i
//   d      in   [7:0] data bit per source, d[i] belongs to source i
//   sel    out  [2:0] mux select, index of the current or last owner
//   grant  out  [7:0] one-hot grant, all zero when idle
//   busy   out  high while a grant is active
//   y      out  registered d[sel], zero when not busy
//   done   out  one-cycle pulse after a grant ends
// -----------------------------------------------------------------------------
module mux8_rr_scheduler #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       y,
  output logic       done
);

`ifdef MUX8_SCHED_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  localparam logic [7:0] CNT_LOAD = 8'(BURST_LEN - 1);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] sel_n;
  logic [7:0] grant_n;
  logic       busy_n, y_n, done_n;

  logic [2:0] win;
  logic [2:0] idx;
  logic       any_req;
  logic       take;

  // Rotating priority search: walk from the farthest offset down to ptr so
  // the nearest requester at or after ptr overwrites earlier candidates.
  always_comb begin
    win     = ptr;
    idx     = ptr;
    any_req = |req;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) win = idx;
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    sel_n   = sel;
    grant_n = grant;
    busy_n  = busy;
    done_n  = 1'b0;
    take    = 1'b0;
    y_n     = busy ? d[sel] : 1'b0;

    case (state)
      GRANT: begin
        // The cycle in which the owner drops req still counts as granted.
        if (cnt == 8'd0 || !req[sel]) begin
          done_n = 1'b1;
`ifdef MUX8_SCHED_GAP_EN
          state_n = GAP;
          grant_n = 8'h00;
          busy_n  = 1'b0;
`else
          take = 1'b1;
`endif
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      // IDLE, and the guard cycle when present, both arbitrate at the edge.
      default: take = 1'b1;
    endcase

    if (take) begin
      if (any_req) begin
        state_n = GRANT;
        sel_n   = win;
        grant_n = 8'b1 << win;
        busy_n  = 1'b1;
        cnt_n   = CNT_LOAD;
        ptr_n   = win + 3'd1;
      end else begin
        state_n = IDLE;
        grant_n = 8'h00;
        busy_n  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= 8'd0;
      sel   <= 3'd0;
      grant <= 8'h00;
      busy  <= 1'b0;
      y     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      grant <= grant_n;
      busy  <= busy_n;
      y     <= y_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_scheduler
//
// Self-checking bench for mux8_rr_scheduler with BURST_LEN=4. A fixed vector
// table covers the single-requester, idle and early-release behaviour; hand
// sequences cover asynchronous reset, round-robin wrap and the data path; a
// randomized run is compared against an owner/usage reference model.
// -----------------------------------------------------------------------------
module tb_mux8_rr_scheduler;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] d;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       y;
  logic       done;

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.BURST_LEN(BL)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d     (d),
    .sel   (sel),
    .grant (grant),
    .busy  (busy),
    .y     (y),
    .done  (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the current owner (-1 when nobody holds the path), the
  // number of cycles it has been granted so far, and the next search start.
  // ---------------------------------------------------------------------------
  int         m_owner;
  int         m_used;
  int         m_ptr;
  logic [2:0] m_sel;
  logic       m_y;
  logic       m_done;

  task automatic model_reset();
    m_owner = -1;
    m_used  = 0;
    m_ptr   = 0;
    m_sel   = 3'd0;
    m_y     = 1'b0;
    m_done  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    bit         pick;
    logic [2:0] cand;
    m_y    = (m_owner >= 0) ? d[m_owner[2:0]] : 1'b0;
    m_done = 1'b0;
    pick   = (m_owner < 0);
    if (m_owner >= 0) begin
      m_used++;
      if (m_used >= BL || !req[m_owner[2:0]]) begin
        m_done = 1'b1;
`ifdef MUX8_SCHED_GAP_EN
        m_owner = -1;
`else
        pick = 1'b1;
`endif
      end
    end
    if (pick) begin
      m_owner = -1;
      for (int k = 0; k < 8; k++) begin
        cand = 3'((m_ptr + k) % 8);
        if (m_owner < 0 && req[cand]) m_owner = int'(cand);
      end
      if (m_owner >= 0) begin
        m_used = 0;
        m_ptr  = (m_owner + 1) % 8;
        m_sel  = m_owner[2:0];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (8'b1 << m_owner[2:0]) : 8'h00;
    check($sformatf("%s.grant", tag), grant, exp_grant);
    check($sformatf("%s.sel", tag), {5'd0, sel}, {5'd0, m_sel});
    check($sformatf("%s.busy", tag), {7'd0, busy}, {7'd0, m_owner >= 0});
    check($sformatf("%s.done", tag), {7'd0, done}, {7'd0, m_done});
    check($sformatf("%s.y", tag), {7'd0, y}, {7'd0, m_y});
  endtask

  // One clock with model tracking; outputs sampled 1 ns after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    d   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied before an edge, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic       y;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Safety net in case a clock edge never arrives.
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 8'h00;
    d   = 8'h00;

`ifndef MUX8_SCHED_GAP_EN
    //            req    d      grant  sel   busy  done  y
    tbl[0]  = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1};  // burst ends, re-grant 3
    tbl[5]  = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0};  // released, go idle
    tbl[7]  = '{8'h00, 8'hFF, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};  // idle: y stays 0, sel holds
    tbl[8]  = '{8'h60, 8'hFF, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};  // ptr=4 -> source 5
    tbl[9]  = '{8'h21, 8'hFF, 8'h20, 3'd5, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{8'h21, 8'hDF, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 8'hDF, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};  // early release, ptr 6 wraps to 0
    tbl[12] = '{8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].grant", i), grant, tbl[i].grant);
      check($sformatf("tbl[%0d].sel", i), {5'd0, sel}, {5'd0, tbl[i].sel});
      check($sformatf("tbl[%0d].busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
      check($sformatf("tbl[%0d].done", i), {7'd0, done}, {7'd0, tbl[i].done});
      check($sformatf("tbl[%0d].y", i), {7'd0, y}, {7'd0, tbl[i].y});
    end
`endif

    // Asynchronous reset in the middle of a burst owned by source 2.
    do_reset();
    req = 8'h04;
    tick("rst_pre0");
    tick("rst_pre1");
    check("rst_pre.grant", grant, 8'h04);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async.grant", grant, 8'h00);
    check("rst_async.sel", {5'd0, sel}, 8'h00);
    check("rst_async.flags", {5'd0, busy, y, done}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 8'h01;
    tick("rst_post");
    check("rst_post.grant", grant, 8'h01);

    // Round robin with everybody requesting: owners 0..7 then back to 0.
    do_reset();
    req = 8'hFF;
    tick("rr_first");
    check("rr_first.grant", grant, 8'h01);
`ifndef MUX8_SCHED_GAP_EN
    for (int i = 0; i < 8 * BL; i++) tick($sformatf("rr[%0d]", i));
    check("rr_wrap.grant", grant, 8'h01);
    check("rr_wrap.done", {7'd0, done}, 8'h01);
`else
    for (int i = 0; i < 8 * (BL + 1); i++) tick($sformatf("rr[%0d]", i));
    check("rr_wrap.grant", grant, 8'h01);
`endif
    for (int i = 0; i < BL; i++) tick($sformatf("rr_tail[%0d]", i));

    // Data path through source 6.
    do_reset();
    req = 8'h40;
    tick("dp_grant");
    check("dp_grant.sel", {5'd0, sel}, 8'h06);
    d = 8'b0100_0000;
    tick("dp_one");
    check("dp_one.y", {7'd0, y}, 8'h01);
    d = 8'h00;
    tick("dp_zero");
    check("dp_zero.y", {7'd0, y}, 8'h00);
    req = 8'h00;
    tick("dp_release");
    d = 8'hFF;
    tick("dp_idle0");
    check("dp_idle0.y", {7'd0, y}, 8'h00);
    tick("dp_idle1");
    check("dp_idle1.y", {7'd0, y}, 8'h00);

`ifdef MUX8_SCHED_GAP_EN
    // Guard cycle between grants.
    do_reset();
    req = 8'h03;
    for (int i = 0; i < BL; i++) begin
      tick($sformatf("gap_g0[%0d]", i));
      check($sformatf("gap_g0[%0d].grant", i), grant, 8'h01);
    end
    tick("gap_idle");
    check("gap_idle.grant", grant, 8'h00);
    check("gap_idle.done", {7'd0, done}, 8'h01);
    tick("gap_g1");
    check("gap_g1.grant", grant, 8'h02);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = 8'($urandom);
          1:       req = 8'($urandom) & 8'($urandom);
          default: req = 8'h00;
        endcase
      end
      d = 8'($urandom);
      tick($sformatf("rnd[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
# mux8_rr_scheduler

Round-robin scheduler that shares an 8:1 multiplexed data path among eight requesters. It arbitrates one-bit request lines, drives the 3-bit select of the 8:1 mux, holds each grant for a bounded burst, and registers the selected data bit. It sits in front of the structural 8:1 mux tree and sequences its select lines so no requester can starve another.

## Interface
- `BURST_LEN`, 4: maximum consecutive granted cycles per grant; legal 1..255.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request per source; bit i = source i; level-sensitive.
- `d` input 8: data bit per source; `d[i]` belongs to source i.
- `sel` output 3: select code for the 8:1 mux; index of the current owner.
- `grant` output 8: one-hot grant; all zero when idle.
- `busy` output 1: high while a grant is active.
- `y` output 1: registered `d[sel]`.
- `done` output 1: one-cycle pulse after a grant ends.

## Operation
- Reset values: `sel`=0, `grant`=0, `busy`=0, `y`=0, `done`=0. Internal state: round-robin pointer `ptr`=0, burst counter `cnt`=0, FSM in IDLE.
- FSM states: IDLE, GRANT, plus GAP when `MUX8_SCHED_GAP_EN` is defined.
- Arbitration: the winner is the first index i with `req[i]`=1, searching `ptr`, `ptr`+1, ... mod 8. On grant, `ptr` ← winner+1 mod 8, wrapping 7→0.
- IDLE: if `|req`=1 at an edge, go to GRANT. At that edge, `sel` ← winner, `grant` ← 1<<winner, `busy` ← 1, and `cnt` ← `BURST_LEN`-1. Otherwise stay in IDLE.
- GRANT end condition, sampled at each edge: `cnt`==0 or `req[sel]`==0. The cycle in which the requester drops `req` still counts as a granted cycle.
- If the end condition is false, `cnt` ← `cnt`-1 and the owner is unchanged.
- If the end condition is true, `done` ← 1 for exactly one cycle, then:
  - Without GAP: re-arbitrate on the same edge, excluding nothing. The new winner may be the same source if it is the only requester. If there are no requests, go to IDLE with `grant`=0 and `busy`=0.
  - With GAP: go to GAP.
- `y`: at every edge, `y` ← `busy` ? `d[sel]` : 0, using the pre-edge `sel` and `busy`. `y` therefore lags the select by one cycle.
- `sel` holds its last value while idle. Only `grant` and `busy` indicate ownership.
- Requests arriving mid-burst do not pre-empt the current owner.
- Asynchronous `rst` mid-burst immediately forces all reset values. It does not pulse `done`.

## Timing
- Request-to-grant latency: `req` high before edge N gives `grant`/`sel` valid after edge N (1 cycle).
- Data latency: `y` reflects `d[sel]` sampled at the edge after `sel` is valid.
- If requests are held, each grant lasts exactly `BURST_LEN` cycles.
- Without GAP, back-to-back grants leave no idle cycle: `grant` switches owner on a single edge, and `done` is high in the new owner's first cycle.
- The worst-case wait for a continuously requesting source is 7×`BURST_LEN` cycles (7×(`BURST_LEN`+1) with GAP).

## Configuration
- `MUX8_SCHED_GAP_EN`:
  - Defined: the GAP state is present. After each grant, exactly one cycle follows with `grant`=0, `busy`=0, and `done`=1. Arbitration then resumes from IDLE on the next edge. This gives the downstream mux a guard cycle.
  - Undefined: no GAP state; grants are back-to-back as described above.

## Test plan
- Reset: assert `rst` mid-burst with `grant`=8'h04 -> all outputs 0 immediately. After release with `req`=8'h01, `grant`=8'h01 after 1 edge.
- Single requester: `req`=8'h08 held, `BURST_LEN`=4 -> `sel`=3 and `grant`=8'h08 for 4 cycles. Then `done` pulses and source 3 is re-granted (no GAP).
- Round-robin fairness: `req`=8'hFF held -> owners 0,1,2,...,7,0, each for 4 cycles. `ptr` wraps 7→0.
- Early release: `req[5]` granted, dropped after 2 granted cycles, with `req`=8'h21 -> grant ends after the cycle `req[5]` falls, `done`=1, and the next owner is 0 (pointer was 6, wraps).
- Data path: owner 6, `d`=8'b0100_0000 then 8'h00 -> `y`=1 one cycle after `sel`=6 with `d[6]`=1, then `y`=0. When idle, `y`=0 regardless of `d`.
- GAP build (`MUX8_SCHED_GAP_EN`): `req`=8'h03 held -> grant 0 for 4 cycles, 1 idle cycle (`grant`=0, `done`=1), then grant 1.
